// File: rtl/axis_frame_pkg.sv
// Shared types and helpers for the AXI-Stream frame generator.
//   state_t   : generator FSM states
//   keep_mask : low-aligned contiguous byte mask with min(rem, kw) bits set
//   beats     : ceil(len / kw), the number of beats a frame occupies
package axis_frame_pkg;

  localparam int MAX_KEEP = 128;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [MAX_KEEP-1:0] keep_mask(input logic [31:0] rem, input int kw);
    logic [MAX_KEEP-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KEEP; i++)
      if (i < kw && 32'(i) < rem) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int beats(input int len, input int kw);
    return (len + kw - 1) / kw;
  endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: takes a byte-length command and emits one frame
// of exactly that many bytes carrying an incrementing byte pattern.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   s_len/_valid/_ready    length command (bytes, or beats when KEEP_ENABLE=0)
//   m_axis_*               output stream (tdata, tkeep, tvalid, tready, tlast)
//   busy                   high while a frame is in progress
// Every output is decoded from registered state only, so neither tready nor
// s_len_valid has a combinational path to an output.
module axis_frame_gen
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  s_len,
  input  logic                  s_len_valid,
  output logic                  s_len_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy
);

  // Length units consumed per beat.
  localparam int STEP = KEEP_ENABLE ? KEEP_WIDTH : 1;

  state_t               state;
  logic [LEN_WIDTH-1:0] rem;
  logic [7:0]           off;

  logic                  sending;
  logic                  last;
  logic [KEEP_WIDTH-1:0] keep_last;

  assign sending   = (state == SEND);
  // rem is never 0 in SEND, so rem <= 1 is the same as rem == 1 in beat mode.
  assign last      = (rem <= LEN_WIDTH'(STEP));
  assign keep_last = KEEP_WIDTH'(keep_mask(32'(rem), KEEP_WIDTH));

  assign s_len_ready   = !sending;
  assign busy          = sending;
  assign m_axis_tvalid = sending;
  assign m_axis_tlast  = sending && last;
  assign m_axis_tkeep  = !sending ? '0 :
                         (KEEP_ENABLE != 0 && last) ? keep_last : '1;

  // Byte lane g carries (off + g) mod 256 where enabled, zero elsewhere.
  for (genvar g = 0; g < KEEP_WIDTH; g++) begin : g_lane
    assign m_axis_tdata[g*8 +: 8] = m_axis_tkeep[g] ? (off + 8'(g)) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      off   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Zero-length commands are consumed and dropped.
          if (s_len_valid && s_len != '0) begin
            rem   <= s_len;
            off   <= 8'd0;
            state <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (last) begin
              state <= IDLE;
            end else begin
              rem <= rem - LEN_WIDTH'(STEP);
              off <= off + 8'(STEP);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_len = '0;
  logic        s_len_valid = 1'b0;
  logic        s_len_ready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        busy;

  axis_frame_gen #(.DATA_WIDTH(64), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_len(s_len), .s_len_valid(s_len_valid), .s_len_ready(s_len_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  // Test vector: command length, tready mode, expected beat count and last keep.
  typedef struct {
    int         len;
    int         mode;   // 0: tready high, 1: 1,0,0 repeating, 2: random
    int         nbeats;
    logic [7:0] last_keep;
  } vec_t;

  beat_t sb[$];
  vec_t  frames[$];

  int errors = 0;
  int checks = 0;
  int mode   = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // tready generator, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (mode)
      1:       m_axis_tready = (cyc % 3 == 0);
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
  end

  // Monitor: scoreboard pop per handshake, stall stability, per-frame length.
  logic        prev_stall = 1'b0;
  beat_t       held;
  int          fr_bytes = 0;
  int          fr_beats = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      fr_bytes   = 0;
      fr_beats   = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data",  m_axis_tdata, held.data);
        chk("stall_keep",  64'(m_axis_tkeep), 64'(held.keep));
        chk("stall_last",  64'(m_axis_tlast), 64'(held.last));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held.data  = m_axis_tdata;
      held.keep  = m_axis_tkeep;
      held.last  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_data", m_axis_tdata, e.data);
          chk("beat_keep", 64'(m_axis_tkeep), 64'(e.keep));
          chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
        end
        fr_bytes += $countones(m_axis_tkeep);
        fr_beats++;
        if (m_axis_tlast) begin
          if (frames.size() == 0) begin
            chk("unexpected_frame", 64'd1, 64'd0);
          end else begin
            vec_t f;
            f = frames.pop_front();
            chk("frame_len",       64'(fr_bytes), 64'(f.len));
            chk("frame_beats",     64'(fr_beats), 64'(f.nbeats));
            chk("frame_last_keep", 64'(m_axis_tkeep), 64'(f.last_keep));
          end
          fr_bytes = 0;
          fr_beats = 0;
        end
      end
    end
  end

  // Reference model: byte b of the frame sits in beat b/8, lane b%8, value b%256.
  task automatic push_frame(input vec_t v);
    int nb;
    nb = (v.len + 7) / 8;
    for (int bt = 0; bt < nb; bt++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int l = 0; l < 8; l++) begin
        int idx;
        idx = bt * 8 + l;
        if (idx < v.len) begin
          e.data[l*8 +: 8] = 8'(idx % 256);
          e.keep[l]        = 1'b1;
        end
      end
      e.last = (bt == nb - 1);
      sb.push_back(e);
    end
    frames.push_back(v);
  endtask

  // Drives one command; returns #1 after the edge at which it was consumed.
  task automatic issue(input vec_t v);
    int t;
    t = 0;
    while (!s_len_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) chk("cmd_ready_timeout", 64'd0, 64'd1);
    s_len       = 16'(v.len);
    s_len_valid = 1'b1;
    if (v.len != 0) push_frame(v);
    @(posedge clk); #1;
    s_len_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!s_len_ready && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) chk("idle_timeout", 64'd0, 64'd1);
    chk("frames_drained", 64'(frames.size()), 64'd0);
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    vecs[0] = '{len: 1,   mode: 0, nbeats: 1,  last_keep: 8'h01};
    vecs[1] = '{len: 8,   mode: 0, nbeats: 1,  last_keep: 8'hFF};
    vecs[2] = '{len: 20,  mode: 0, nbeats: 3,  last_keep: 8'h0F};
    vecs[3] = '{len: 17,  mode: 1, nbeats: 3,  last_keep: 8'h01};
    vecs[4] = '{len: 0,   mode: 0, nbeats: 0,  last_keep: 8'h00};
    vecs[5] = '{len: 300, mode: 0, nbeats: 38, last_keep: 8'h0F};
    vecs[6] = '{len: 9,   mode: 2, nbeats: 2,  last_keep: 8'h01};
    vecs[7] = '{len: 61,  mode: 2, nbeats: 8,  last_keep: 8'h1F};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(s_len_ready),   64'd1);
    chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_last",  64'(m_axis_tlast),  64'd0);
    chk("rst_keep",  64'(m_axis_tkeep),  64'd0);
    chk("rst_data",  m_axis_tdata,       64'd0);
    chk("rst_busy",  64'(busy),          64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      issue(vecs[i]);
      if (vecs[i].len == 0) begin
        // Dropped: no beat, ready again immediately; next command follows at once.
        chk("zero_no_valid", 64'(m_axis_tvalid), 64'd0);
        chk("zero_ready",    64'(s_len_ready),   64'd1);
        continue;
      end
      chk("first_beat_latency", 64'(m_axis_tvalid), 64'd1);
      chk("busy_in_frame",      64'(busy),          64'd1);
      chk("ready_low_in_frame", 64'(s_len_ready),   64'd0);
      if (vecs[i].len == 8)
        chk("len8_data", m_axis_tdata, 64'h07060504_03020100);
      if (vecs[i].len == 1) begin
        @(posedge clk); #1;
        chk("len1_ready_back", 64'(s_len_ready), 64'd1);
      end
      wait_idle();
    end

    // Reset during beat 2 of a 64-byte frame
    mode = 0;
    v = '{len: 64, mode: 0, nbeats: 8, last_keep: 8'hFF};
    issue(v);
    @(posedge clk); #1;
    chk("beat2_off", m_axis_tdata, 64'h0F0E0D0C_0B0A0908);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_ready", 64'(s_len_ready),   64'd1);
    chk("midrst_last",  64'(m_axis_tlast),  64'd0);
    rst = 1'b0;
    sb.delete();
    frames.delete();
    v = '{len: 8, mode: 0, nbeats: 1, last_keep: 8'hFF};
    issue(v);
    chk("post_rst_data", m_axis_tdata, 64'h07060504_03020100);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

Transmit-side counterpart of the frame-length monitor. It accepts a byte-length command and emits one AXI-Stream frame of exactly that many bytes, with an incrementing byte pattern, a low-aligned contiguous `tkeep` on the last beat, and `tlast`. It sits at the head of a stream path as a traffic source for loopback and length-checking tests. Its output, fed to the length monitor, must reproduce the commanded length.

## Interface

Parameters:
- `DATA_WIDTH`, 64, stream data width in bits.
- `KEEP_ENABLE`, `DATA_WIDTH>8`, enables `tkeep`. When 0, `tkeep` is tied all-ones and length is counted in beats.
- `KEEP_WIDTH`, `DATA_WIDTH/8`, number of byte lanes.
- `LEN_WIDTH`, 16, command length width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_len`  in  LEN_WIDTH  frame length in bytes (in beats when `KEEP_ENABLE=0`).
- `s_len_valid`  in  1  command valid.
- `s_len_ready`  out  1  command ready.
- `m_axis_tdata`  out  DATA_WIDTH  frame data.
- `m_axis_tkeep`  out  KEEP_WIDTH  byte enables.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  last beat of frame.
- `busy`  out  1  high while a frame is in progress.

## Operation

- FSM states: IDLE and SEND.
- IDLE:
  - `s_len_ready`=1.
  - On `s_len_valid`, the command is consumed.
  - If `s_len`=0: the command is dropped, no beat is emitted, and the FSM stays in IDLE.
  - Otherwise: load `rem`=`s_len` and `off`=0, then go to SEND.
- SEND:
  - `s_len_ready`=0 and `busy`=1. `m_axis_tvalid`=1 continuously until the last beat is accepted.
  - Beat content is a function of `rem` and `off`, held in registers:
    - `last` = (`rem` <= KEEP_WIDTH).
    - `tkeep` = all-ones if not `last`; otherwise the low `rem` bits set.
    - Byte lane i carries (`off`+i) mod 256 where `tkeep[i]`=1, and 0 where `tkeep[i]`=0.
    - `tlast` = `last`.
  - On a handshake (`tvalid`&&`tready`):
    - If `last`: return to IDLE.
    - Otherwise: `rem` -= KEEP_WIDTH; `off` += KEEP_WIDTH, keeping it mod 256 (8-bit wrap).
- `KEEP_ENABLE`=0: one unit per beat. `last` = (`rem`==1), `rem` decrements by 1, and `off` increments by 1.
- Maximum length is 2^LEN_WIDTH−1. `rem` is LEN_WIDTH bits and never underflows, because decrementing only occurs when `rem` > KEEP_WIDTH.
- Backpressure: while `tvalid`&&!`tready`, `tdata`, `tkeep` and `tlast` hold stable.
- Command side: `s_len` is ignored outside IDLE. An upstream source holding `s_len_valid` simply waits.

## Timing

- Reset values: `s_len_ready`=1, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tkeep`=0, `m_axis_tdata`=0, `busy`=0, FSM=IDLE.
- Reset mid-frame: the frame is abandoned with no `tlast`, and the next cycle shows the reset values.
- All outputs are registered or decoded from state only. There is no combinational path from `m_axis_tready` or `s_len_valid` to any output.
- Latency: a command accepted in cycle N produces its first beat valid in cycle N+1.
- A frame of B beats with `tready` held high occupies cycles N+1..N+B.
- Gap between frames:
  - `s_len_ready` returns high in the cycle after the last beat is accepted.
  - Minimum inter-frame spacing is one idle cycle.
  - A zero-length command costs one cycle.

## Structure

- Shared package `axis_frame_pkg`:
  - function `keep_mask(rem, KEEP_WIDTH)` returning the low-aligned contiguous mask.
  - function `beats(len, KEEP_WIDTH)` returning ceil(len/KEEP_WIDTH), for the bench.
  - state typedef {IDLE, SEND}.
- No sub-module. The byte-pattern generator is a generate loop inside the block.

## Test plan

All scenarios use DATA_WIDTH=64 unless noted.

- `s_len`=1 -> one beat: `tkeep`=0x01, `tlast`=1, `tdata`=0x00000000_00000000; `s_len_ready` high 2 cycles after the command.
- `s_len`=8 -> one beat: `tkeep`=0xFF, `tdata`=0x07060504_03020100, `tlast`=1.
- `s_len`=20, `tready`=1 -> 3 consecutive beats:
  - `tkeep` FF, FF, 0F.
  - Last `tdata`=0x00000000_13121110.
  - `tlast` only on beat 3.
  - The length monitor reports 20.
- `s_len`=17, `tready` toggling 1,0,0,1,… -> exactly 3 beats (keep FF, FF, 01); outputs stable across every stalled cycle; 0x10 in lane 0 of beat 3.
- `s_len`=0, then `s_len`=300 back-to-back -> no beat for the first command.
  - Second frame: 38 beats, last `tkeep`=0x0F.
  - Byte 256 = 0x00 (pattern wraps).
- `rst` asserted during beat 2 of `s_len`=64 -> next cycle `tvalid`=0 and `s_len_ready`=1; no `tlast` emitted. A following `s_len`=8 produces a clean frame starting at byte 0x00.
